// File: rtl/ni_rx_sequencer_if.sv
// Signal bundle between the NI receive sequencer and its neighbours (admit control and consumers).
// The master modport is the sequencer side; the slave modport is the surrounding logic.
interface ni_rx_sequencer_if #(
  parameter int CNT_WIDTH = 4
);
  logic                 rx_enable;
  logic                 flit_valid;
  logic                 full_header;
  logic                 full_payload;
  logic                 packet_finished;
  logic                 hdr_is_read;
  logic                 hdr_taken;
  logic                 pld_taken;
  logic                 receiving_header;
  logic                 receiving_payload;
  logic                 clear_flit_count;
  logic                 packet_type_is_read;
  logic                 hdr_ready;
  logic                 pld_ready;
  logic                 busy;
  logic [CNT_WIDTH-1:0] pkt_count;
  logic                 err_timeout;

  modport master (
    input  rx_enable, flit_valid, full_header, full_payload, packet_finished,
           hdr_is_read, hdr_taken, pld_taken,
    output receiving_header, receiving_payload, clear_flit_count, packet_type_is_read,
           hdr_ready, pld_ready, busy, pkt_count, err_timeout
  );

  modport slave (
    output rx_enable, flit_valid, full_header, full_payload, packet_finished,
           hdr_is_read, hdr_taken, pld_taken,
    input  receiving_header, receiving_payload, clear_flit_count, packet_type_is_read,
           hdr_ready, pld_ready, busy, pkt_count, err_timeout
  );
endinterface

// File: rtl/ni_rx_sequencer.sv
// Initiator NI receive-path control FSM: header phase, payload phase, consumer handshakes, packet count.
// Optional payload-stall watchdog enabled by defining NI_RX_TIMEOUT_EN.
module ni_rx_sequencer #(
  parameter int CNT_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  ni_rx_sequencer_if.master bus_io
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RX_HDR  = 3'd1,
    HDR_OUT = 3'd2,
    RX_PLD  = 3'd3,
    PLD_OUT = 3'd4,
    CLEAR   = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic                 recvHdr_q, recvPld_q, clearCnt_q, typeRead_q;
  logic                 hdrReady_q, pldReady_q, busy_q;
  logic [CNT_WIDTH-1:0] pktCount_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus_io.rx_enable) state_d = RX_HDR;
      RX_HDR:  if (bus_io.full_header) state_d = HDR_OUT;
      HDR_OUT: if (bus_io.hdr_taken) state_d = bus_io.packet_finished ? CLEAR : RX_PLD;
      RX_PLD:  if (bus_io.full_payload || bus_io.packet_finished) state_d = PLD_OUT;
      PLD_OUT: if (bus_io.pld_taken) state_d = CLEAR;
      CLEAR:   state_d = bus_io.rx_enable ? RX_HDR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so each one is a clean Moore output of the current state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      recvHdr_q  <= 1'b0;
      recvPld_q  <= 1'b0;
      clearCnt_q <= 1'b0;
      typeRead_q <= 1'b0;
      hdrReady_q <= 1'b0;
      pldReady_q <= 1'b0;
      busy_q     <= 1'b0;
      pktCount_q <= '0;
    end else begin
      state_q    <= state_d;
      recvHdr_q  <= (state_d == RX_HDR);
      recvPld_q  <= (state_d == RX_PLD);
      clearCnt_q <= (state_d == CLEAR);
      hdrReady_q <= (state_d == HDR_OUT);
      pldReady_q <= (state_d == PLD_OUT);
      busy_q     <= (state_d != IDLE);
      if (state_q == RX_HDR && bus_io.full_header) begin
        typeRead_q <= bus_io.hdr_is_read;
      end
      if (state_d == CLEAR) begin
        pktCount_q <= pktCount_q + CNT_WIDTH'(1);
      end
    end
  end

  assign bus_io.receiving_header    = recvHdr_q;
  assign bus_io.receiving_payload   = recvPld_q;
  assign bus_io.clear_flit_count    = clearCnt_q;
  assign bus_io.packet_type_is_read = typeRead_q;
  assign bus_io.hdr_ready           = hdrReady_q;
  assign bus_io.pld_ready           = pldReady_q;
  assign bus_io.busy                = busy_q;
  assign bus_io.pkt_count           = pktCount_q;

`ifdef NI_RX_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] TimeoutLimit = CNT_WIDTH'(TIMEOUT_CYCLES);

  logic [CNT_WIDTH-1:0] wdog_q, wdogInc;
  logic                 errTimeout_q;

  assign wdogInc = (wdog_q == '1) ? wdog_q : wdog_q + CNT_WIDTH'(1);

  // The watchdog only observes payload stalls; the error is sticky and never disturbs the FSM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wdog_q       <= '0;
      errTimeout_q <= 1'b0;
    end else if (state_q == RX_PLD && !bus_io.flit_valid) begin
      wdog_q <= wdogInc;
      if (wdogInc >= TimeoutLimit) begin
        errTimeout_q <= 1'b1;
      end
    end else begin
      wdog_q <= '0;
    end
  end

  assign bus_io.err_timeout = errTimeout_q;
`else
  localparam int UnusedTimeoutCycles = TIMEOUT_CYCLES;
  logic unusedFlitValid;

  assign unusedFlitValid    = bus_io.flit_valid;
  assign bus_io.err_timeout = 1'b0;
`endif

endmodule
